// File: rtl/cx_pkg.sv
// Shared definitions for the CX switch-to-CXU interface: function codes,
// status bit positions, data widths and the responder FSM state type.
package cx_pkg;

  localparam int CX_DATA_W     = 32;
  localparam int CX_STATUS_W   = 4;
  localparam int CX_STATE_ID_W = 2;

  localparam int CX_ST_ERR_FUNC  = 0;
  localparam int CX_ST_OVF       = 1;
  localparam int CX_ST_ERR_STATE = 2;

  typedef enum logic [2:0] {
    CXU_MUL    = 3'd0,
    CXU_MAC    = 3'd1,
    CXU_RDACC  = 3'd2,
    CXU_WRACC  = 3'd3,
    CXU_CLRACC = 3'd4
  } cxu_mac_func_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } cxu_mac_state_e;

endpackage

// File: rtl/cxu_mac_mul.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, finishing as
// soon as no set bits remain. o_done/o_p describe the step taken this cycle.
module cxu_mac_mul
  import cx_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  input  logic [CX_DATA_W-1:0] i_a,
  input  logic [CX_DATA_W-1:0] i_b,
  output logic                 o_done,
  output logic [CX_DATA_W-1:0] o_p
);

  logic                 r_run;
  logic [CX_DATA_W-1:0] r_mcand;
  logic [CX_DATA_W-1:0] r_mplier;
  logic [CX_DATA_W-1:0] r_prod;

  // Product after this cycle's step, so the caller can finish without an extra cycle.
  assign o_p    = r_prod + (r_mplier[0] ? r_mcand : '0);
  assign o_done = r_run && (r_mplier[CX_DATA_W-1:1] == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_run    <= 1'b0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_prod   <= '0;
    end else if (i_start) begin
      r_run    <= 1'b1;
      r_mcand  <= i_a;
      r_mplier <= i_b;
      r_prod   <= '0;
    end else if (r_run) begin
      r_prod   <= o_p;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      if (o_done) r_run <= 1'b0;
    end
  end

endmodule

// File: rtl/cxu_mac.sv
// Stateful multiply-accumulate CXU: responder FSM, accumulator contexts,
// error decode and registered response outputs.
module cxu_mac
  import cx_pkg::*;
#(
  parameter int N_STATES   = 4,
  parameter int STATE_ID_W = CX_STATE_ID_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cxu_valid_i,
  input  logic [2:0]             cxu_func_i,
  input  logic [STATE_ID_W-1:0]  cxu_state_id_i,
  input  logic [CX_DATA_W-1:0]   cxu_data0_i,
  input  logic [CX_DATA_W-1:0]   cxu_data1_i,
  output logic                   cxu_ready_o,
  output logic [CX_DATA_W-1:0]   cxu_resp_o,
  output logic [CX_STATUS_W-1:0] cxu_status_o,
  output logic                   busy_o
);

  localparam int ACC_DEPTH = 1 << STATE_ID_W;

  cxu_mac_state_e         r_state;
  logic [2:0]             r_func;
  logic [STATE_ID_W-1:0]  r_state_id;
  logic [CX_DATA_W-1:0]   r_acc [ACC_DEPTH];
  logic                   r_ready;
  logic [CX_DATA_W-1:0]   r_resp;
  logic [CX_STATUS_W-1:0] r_status;
  logic                   r_busy;

  logic                   w_in_idle;
  logic [2:0]             w_func;
  logic [STATE_ID_W-1:0]  w_state_id;
  logic                   w_err_func;
  logic                   w_err_state;
  logic                   w_start;
  logic                   w_finish;
  logic                   w_mul_done;
  logic [CX_DATA_W-1:0]   w_mul_p;
  logic [CX_DATA_W-1:0]   w_product;
  logic [CX_DATA_W-1:0]   w_acc_old;
  logic [CX_DATA_W:0]     w_sum;
  logic [CX_DATA_W-1:0]   w_resp;
  logic [CX_STATUS_W-1:0] w_status;
  logic                   w_acc_we;
  logic [CX_DATA_W-1:0]   w_acc_wdata;

  // In IDLE the request is decoded straight from the inputs; in BUSY from the latched copy.
  assign w_in_idle   = (r_state == ST_IDLE);
  assign w_func      = w_in_idle ? cxu_func_i : r_func;
  assign w_state_id  = w_in_idle ? cxu_state_id_i : r_state_id;
  assign w_err_func  = (w_func > 3'(CXU_CLRACC));
  assign w_err_state = (int'(w_state_id) >= N_STATES);
  assign w_acc_old   = r_acc[w_state_id];
  assign w_product   = w_in_idle ? '0 : w_mul_p;

  assign w_start  = w_in_idle && cxu_valid_i && !w_err_func && !w_err_state &&
                    (cxu_data1_i != '0) &&
                    (w_func == 3'(CXU_MUL) || w_func == 3'(CXU_MAC));
  assign w_finish = (w_in_idle && cxu_valid_i && !w_start) ||
                    (r_state == ST_BUSY && w_mul_done);

  cxu_mac_mul u_mul (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_start),
    .i_a     (cxu_data0_i),
    .i_b     (cxu_data1_i),
    .o_done  (w_mul_done),
    .o_p     (w_mul_p)
  );

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    w_sum       = {1'b0, w_acc_old} + {1'b0, w_product};
    w_resp      = '0;
    w_status    = '0;
    w_acc_we    = 1'b0;
    w_acc_wdata = w_acc_old;
    w_status[CX_ST_ERR_FUNC]  = w_err_func;
    w_status[CX_ST_ERR_STATE] = w_err_state;
    if (!w_err_func && !w_err_state) begin
      case (cxu_mac_func_e'(w_func))
        CXU_MUL: w_resp = w_product;
        CXU_MAC: begin
          w_resp              = w_sum[CX_DATA_W-1:0];
          w_status[CX_ST_OVF] = w_sum[CX_DATA_W];
          w_acc_we            = 1'b1;
          w_acc_wdata         = w_sum[CX_DATA_W-1:0];
        end
        CXU_RDACC: w_resp = w_acc_old;
        CXU_WRACC: begin
          w_resp      = w_acc_old;
          w_acc_we    = 1'b1;
          w_acc_wdata = cxu_data0_i;
        end
        CXU_CLRACC: begin
          w_resp      = w_acc_old;
          w_acc_we    = 1'b1;
          w_acc_wdata = '0;
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_func     <= '0;
      r_state_id <= '0;
      r_ready    <= 1'b0;
      r_resp     <= '0;
      r_status   <= '0;
      r_busy     <= 1'b0;
      // NOTE: the accumulators are architectural state that must read 0 after reset, so this array is reset explicitly.
      for (int i = 0; i < ACC_DEPTH; i++) r_acc[i] <= '0;
    end else begin
      r_ready  <= 1'b0;
      r_resp   <= '0;
      r_status <= '0;
      if (w_finish) begin
        r_ready  <= 1'b1;
        r_resp   <= w_resp;
        r_status <= w_status;
        if (w_acc_we) r_acc[w_state_id] <= w_acc_wdata;
      end
      case (r_state)
        ST_IDLE: if (cxu_valid_i) begin
          r_func     <= cxu_func_i;
          r_state_id <= cxu_state_id_i;
          r_busy     <= 1'b1;
          r_state    <= w_start ? ST_BUSY : ST_DONE;
        end
        ST_BUSY: if (w_mul_done) r_state <= ST_DONE;
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cxu_ready_o  = r_ready;
  assign cxu_resp_o   = r_resp;
  assign cxu_status_o = r_status;
  assign busy_o       = r_busy;

endmodule
